coherence_bus_arbiter: RTL

- Shared snooping-bus controller for a two-core SMP.
- Arbitrates each core's cache-miss and invalidate requests. For the winning request it sequences four things: snoop of the other core's cache, cache-to-cache transfer, unified-memory fill, and invalidation of the stale peer copy.
- Sits between the two cpu instances and the unified memory. It drives each core's cpu_search, BOCI, grant, cpu_datasel and invalidate_from_other_cpu inputs.

---
 rtl/coherence_bus_arbiter_if.sv | 44 ++++
 rtl/coherence_bus_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_arbiter_if.sv
// Snooping-bus signal bundle between the two cores, unified memory and the arbiter.
// master = core/memory side, slave = arbiter; bus_err exists only with ARB_TIMEOUT_EN.
interface coherence_bus_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int OP_W   = 2
);
    logic [1:0]             read_miss;
    logic [1:0]             write_miss;
    logic [1:0]             invalidate;
    logic [ADDR_W-1:0]      BICO0;
    logic [ADDR_W-1:0]      BICO1;
    logic [1:0]             cpu_search_found;
    logic                   u_rdy;
    logic [1:0]             grant;
    logic [1:0]             cpu_search;
    logic [OP_W+ADDR_W-1:0] BOCI;
    logic [1:0]             cpu_datasel0;
    logic [1:0]             cpu_datasel1;
    logic [1:0]             invalidate_from_other_cpu;
    logic [ADDR_W-1:0]      u_addr;
    logic                   u_re;
    logic                   bus_busy;
`ifdef ARB_TIMEOUT_EN
    logic                   bus_err;
`endif

    modport master (
        output read_miss, write_miss, invalidate, BICO0, BICO1, cpu_search_found, u_rdy,
        input  grant, cpu_search, BOCI, cpu_datasel0, cpu_datasel1,
               invalidate_from_other_cpu, u_addr, u_re, bus_busy
`ifdef ARB_TIMEOUT_EN
        , input bus_err
`endif
    );

    modport slave (
        input  read_miss, write_miss, invalidate, BICO0, BICO1, cpu_search_found, u_rdy,
        output grant, cpu_search, BOCI, cpu_datasel0, cpu_datasel1,
               invalidate_from_other_cpu, u_addr, u_re, bus_busy
`ifdef ARB_TIMEOUT_EN
        , output bus_err
`endif
    );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// Two-core snooping-bus arbiter: round-robin pick, snoop peer, peer transfer or memory fill, invalidate, grant.
// Latency: 4 cycles request-to-grant (invalidate, peer read hit), 5 (write-miss peer hit), 4 + memory wait (fill).
// Backpressure: requests are levels held until grant; MEM stalls on u_rdy, bounded to 1023 cycles when ARB_TIMEOUT_EN is defined.
module coherence_bus_arbiter #(
    parameter int ADDR_W = 11,
    parameter int OP_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    coherence_bus_arbiter_if.slave bus
);
    localparam logic [OP_W-1:0] OP_RD   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_WR   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_INV  = OP_W'(3);
    localparam logic [1:0]      DS_NONE = 2'b00;
    localparam logic [1:0]      DS_MEM  = 2'b01;
    localparam logic [1:0]      DS_PEER = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNOOP,
        S_CHECK,
        S_XFER,
        S_MEM,
        S_INV,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              found_q, found_d;
    logic [1:0]        datasel_q, datasel_d;
    logic              last_grant_q, last_grant_d;

    logic [1:0]        req;
    logic              win;
    logic [OP_W-1:0]   win_op;
    logic [ADDR_W-1:0] win_addr;
    logic              peer;
    logic              mem_timeout;

    logic [1:0]             grant_o;
    logic [1:0]             search_o;
    logic [OP_W+ADDR_W-1:0] boci_o;
    logic [1:0]             inval_o;
    logic [ADDR_W-1:0]      u_addr_o;
    logic                   u_re_o;

    assign req  = bus.read_miss | bus.write_miss | bus.invalidate;
    assign peer = ~owner_q;

    // Tie goes to the core that did not win last; within a core invalidate beats write beats read.
    always_comb begin
        win = (req == 2'b11) ? ~last_grant_q : req[1];
        if (bus.invalidate[win]) begin
            win_op = OP_INV;
        end else if (bus.write_miss[win]) begin
            win_op = OP_WR;
        end else begin
            win_op = OP_RD;
        end
        win_addr = win ? bus.BICO1 : bus.BICO0;
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'd1022;
    logic [9:0] tmo_cnt_q, tmo_cnt_d;

    // Count value 1022 marks the 1023rd MEM cycle; give up there unless u_rdy arrives in it.
    assign mem_timeout = (state_q == S_MEM) && !bus.u_rdy && (tmo_cnt_q == TMO_LAST);
    assign bus.bus_err = mem_timeout;

    always_comb begin
        tmo_cnt_d = (state_q == S_MEM) ? tmo_cnt_q + 10'd1 : 10'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 10'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign mem_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            op_q         <= '0;
            addr_q       <= '0;
            found_q      <= 1'b0;
            datasel_q    <= DS_NONE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            found_q      <= found_d;
            datasel_q    <= datasel_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        op_d         = op_q;
        addr_d       = addr_q;
        found_d      = found_q;
        datasel_d    = datasel_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    owner_d   = win;
                    op_d      = win_op;
                    addr_d    = win_addr;
                    found_d   = 1'b0;
                    datasel_d = DS_NONE;
                    state_d   = S_SNOOP;
                end
            end
            S_SNOOP: state_d = S_CHECK;
            S_CHECK: begin
                found_d = bus.cpu_search_found[peer];
                if (op_q == OP_INV) begin
                    state_d = S_INV;
                end else if (bus.cpu_search_found[peer]) begin
                    datasel_d = DS_PEER;
                    state_d   = S_XFER;
                end else begin
                    datasel_d = DS_MEM;
                    state_d   = S_MEM;
                end
            end
            S_XFER: state_d = (op_q == OP_WR) ? S_INV : S_DONE;
            S_MEM: begin
                if (bus.u_rdy) begin
                    state_d = (op_q == OP_WR && found_q) ? S_INV : S_DONE;
                end else if (mem_timeout) begin
                    datasel_d = DS_NONE;
                    state_d   = S_DONE;
                end
            end
            S_INV: state_d = S_DONE;
            S_DONE: begin
                last_grant_d = owner_q;
                datasel_d    = DS_NONE;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // BOCI stays up from SNOOP through XFER so the peer can source the line.
    always_comb begin
        grant_o  = 2'b00;
        search_o = 2'b00;
        boci_o   = '0;
        inval_o  = 2'b00;
        u_addr_o = '0;
        u_re_o   = 1'b0;
        case (state_q)
            S_SNOOP: begin
                search_o[peer] = 1'b1;
                boci_o         = {op_q, addr_q};
            end
            S_CHECK, S_XFER: boci_o = {op_q, addr_q};
            S_MEM: begin
                u_re_o   = 1'b1;
                u_addr_o = addr_q;
            end
            S_INV:   inval_o[peer]    = 1'b1;
            S_DONE:  grant_o[owner_q] = 1'b1;
            default: ;
        endcase
    end

    assign bus.grant                     = grant_o;
    assign bus.cpu_search                = search_o;
    assign bus.BOCI                      = boci_o;
    assign bus.invalidate_from_other_cpu = inval_o;
    assign bus.u_addr                    = u_addr_o;
    assign bus.u_re                      = u_re_o;
    assign bus.bus_busy                  = (state_q != S_IDLE);
    assign bus.cpu_datasel0              = owner_q ? DS_NONE : datasel_q;
    assign bus.cpu_datasel1              = owner_q ? datasel_q : DS_NONE;

endmodule
